// File: rtl/usb_rx_pkg.sv
// Shared USB receive definitions: FSM state encoding, field widths and the PID check.
package usb_rx_pkg;

   localparam int unsigned PID_BITS  = 8;
   localparam int unsigned STUFF_RUN = 6;
   localparam int unsigned ONES_W    = 3;
   localparam int unsigned PID_CNT_W = 3;
   localparam int unsigned LEN_W     = 11;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_PID  = 2'd1;
   localparam state_t ST_DATA = 2'd2;
   localparam state_t ST_ERR  = 2'd3;

   // Upper nibble must be the one's complement of the lower nibble.
   function automatic logic pid_ok(input logic [PID_BITS-1:0] p);
      return p[7:4] == ~p[3:0];
   endfunction

endpackage

// File: rtl/bit_unstuff_core.sv
// Raw-bit ones counter with stuffed-bit detection; flags are combinational on the current bit.
module bit_unstuff_core
   import usb_rx_pkg::*;
#(
   parameter int unsigned SYNC_ONES = 1
)
(
   input  logic clock,
   input  logic reset_n,
   input  logic line_bit,
   input  logic bit_en,
   input  logic preload,
   input  logic clear,
   output logic drop_c,
   output logic viol_c
);

   logic [ONES_W-1:0] ones_cnt;
   logic [ONES_W-1:0] ones_cur_c;

   // A packet start replaces the running count with the SYNC tail before this bit is judged.
   always_comb begin
      ones_cur_c = preload ? ONES_W'(SYNC_ONES) : ones_cnt;
      drop_c     = bit_en && (ones_cur_c == ONES_W'(STUFF_RUN));
      viol_c     = drop_c && line_bit;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ones_cnt <= '0;
      end else if (clear) begin
         ones_cnt <= '0;
      end else if (bit_en) begin
         ones_cnt <= (drop_c || !line_bit) ? '0 : ones_cur_c + ONES_W'(1);
      end else if (preload) begin
         ones_cnt <= ones_cur_c;
      end
   end

endmodule

// File: rtl/bit_unstuff_rx.sv
// USB receive bit unstuffer: PID capture/check, payload streaming and length check.
// Define USB_RX_STUFF_ERR_EN to turn stuffed-one violations into an ERR state and stuff_err.
module bit_unstuff_rx
   import usb_rx_pkg::*;
#(
   parameter int unsigned SYNC_ONES = 1
)
(
   input  logic                clock,
   input  logic                reset_n,
   input  logic                rx_bit,
   input  logic                rx_valid,
   input  logic                rx_sop,
   input  logic                rx_eop,
   output logic                out_bit,
   output logic                bs_sending,
   output logic [PID_BITS-1:0] pid,
   output logic                pid_valid,
   output logic                pid_err,
   output logic                stuff_err,
   output logic                len_err,
   output logic                pkt_done
);

`ifdef USB_RX_STUFF_ERR_EN
   localparam logic STUFF_ERR_EN = 1'b1;
`else
   localparam logic STUFF_ERR_EN = 1'b0;
`endif

   state_t               state, state_n;
   logic [PID_CNT_W-1:0] pid_cnt, pid_cnt_n;
   logic [LEN_W-1:0]     len_cnt, len_cnt_n;
   logic [PID_BITS-1:0]  pid_n, pid_shift_c;
   logic                 out_bit_n, bs_sending_n, pid_valid_n, pid_err_n;
   logic                 stuff_err_n, len_err_n, pkt_done_n;
   logic                 sop_go_c, bit_en_c, drop_c, viol_c;

   // End of packet outranks a coincident start and any coincident bit.
   assign sop_go_c = rx_sop && !rx_eop;
   assign bit_en_c = rx_valid && !rx_eop && (sop_go_c || (state != ST_IDLE));

   bit_unstuff_core #(
      .SYNC_ONES (SYNC_ONES)
   ) u_core (
      .clock    (clock),
      .reset_n  (reset_n),
      .line_bit (rx_bit),
      .bit_en   (bit_en_c),
      .preload  (sop_go_c),
      .clear    (rx_eop),
      .drop_c   (drop_c),
      .viol_c   (viol_c)
   );

   always_comb begin
      state_n      = state;
      pid_cnt_n    = pid_cnt;
      len_cnt_n    = len_cnt;
      pid_n        = pid;
      out_bit_n    = out_bit;
      bs_sending_n = 1'b0;
      pid_valid_n  = 1'b0;
      pid_err_n    = 1'b0;
      stuff_err_n  = stuff_err;
      len_err_n    = 1'b0;
      pkt_done_n   = 1'b0;
      pid_shift_c  = {rx_bit, pid[PID_BITS-1:1]};

      if (rx_eop) begin
         state_n   = ST_IDLE;
         pid_cnt_n = '0;
         len_cnt_n = '0;
         if (state != ST_IDLE) begin
            pkt_done_n = 1'b1;
            len_err_n  = (len_cnt[2:0] != 3'd0);
         end
      end else if (rx_sop) begin
         // Start (or restart after an abort) of PID capture; the sop bit is the first PID bit.
         state_n     = ST_PID;
         pid_cnt_n   = '0;
         len_cnt_n   = '0;
         stuff_err_n = 1'b0;
         if (bit_en_c && !drop_c) begin
            pid_n     = pid_shift_c;
            pid_cnt_n = PID_CNT_W'(1);
         end
      end else if (bit_en_c) begin
         case (state)
            ST_PID: begin
               if (STUFF_ERR_EN && viol_c) begin
                  state_n     = ST_ERR;
                  stuff_err_n = 1'b1;
               end else if (!drop_c) begin
                  pid_n     = pid_shift_c;
                  pid_cnt_n = pid_cnt + PID_CNT_W'(1);
                  if (pid_cnt == PID_CNT_W'(PID_BITS - 1)) begin
                     state_n     = ST_DATA;
                     pid_valid_n = pid_ok(pid_shift_c);
                     pid_err_n   = !pid_ok(pid_shift_c);
                  end
               end
            end
            ST_DATA: begin
               if (STUFF_ERR_EN && viol_c) begin
                  state_n     = ST_ERR;
                  stuff_err_n = 1'b1;
               end else if (!drop_c) begin
                  out_bit_n    = rx_bit;
                  bs_sending_n = 1'b1;
                  if (len_cnt != '1) begin
                     len_cnt_n = len_cnt + LEN_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         pid_cnt    <= '0;
         len_cnt    <= '0;
         pid        <= '0;
         out_bit    <= 1'b0;
         bs_sending <= 1'b0;
         pid_valid  <= 1'b0;
         pid_err    <= 1'b0;
         stuff_err  <= 1'b0;
         len_err    <= 1'b0;
         pkt_done   <= 1'b0;
      end else begin
         state      <= state_n;
         pid_cnt    <= pid_cnt_n;
         len_cnt    <= len_cnt_n;
         pid        <= pid_n;
         out_bit    <= out_bit_n;
         bs_sending <= bs_sending_n;
         pid_valid  <= pid_valid_n;
         pid_err    <= pid_err_n;
         stuff_err  <= stuff_err_n;
         len_err    <= len_err_n;
         pkt_done   <= pkt_done_n;
      end
   end

endmodule

// File: tb/tb_bit_unstuff_rx.sv
// Scoreboard bench for bit_unstuff_rx: directed packets, expected events queued, monitor compares.
module tb_bit_unstuff_rx;

   logic       clock    = 1'b0;
   logic       reset_n  = 1'b0;
   logic       rx_bit   = 1'b0;
   logic       rx_valid = 1'b0;
   logic       rx_sop   = 1'b0;
   logic       rx_eop   = 1'b0;
   logic       out_bit, bs_sending, pid_valid, pid_err, stuff_err, len_err, pkt_done;
   logic [7:0] pid;

   int n_checks   = 0;
   int n_fail     = 0;
   int bs_count   = 0;
   int ones_count = 0;

   logic       exp_bits[$];
   logic [8:0] exp_pid[$];   // {pid_valid, pid}
   logic [1:0] exp_done[$];  // {len_err, stuff_err}

`ifdef USB_RX_STUFF_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   bit_unstuff_rx #(.SYNC_ONES(1)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .rx_bit     (rx_bit),
      .rx_valid   (rx_valid),
      .rx_sop     (rx_sop),
      .rx_eop     (rx_eop),
      .out_bit    (out_bit),
      .bs_sending (bs_sending),
      .pid        (pid),
      .pid_valid  (pid_valid),
      .pid_err    (pid_err),
      .stuff_err  (stuff_err),
      .len_err    (len_err),
      .pkt_done   (pkt_done)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_bits(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) exp_bits.push_back(v[i]);
   endtask

   task automatic push_pid(input logic ok, input logic [7:0] p);
      exp_pid.push_back({ok, p});
   endtask

   task automatic push_done(input logic le, input logic se);
      exp_done.push_back({le, se});
   endtask

   // Raw wire bits, first bit in raw[0]; optionally checks the stuffing gap around gap_idx.
   task automatic send(input logic [63:0] raw, input int n, input logic with_sop, input int gap_idx);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (gap_idx >= 0 && i == gap_idx)     check("pre_gap_bs_sending", bs_sending, 1'b1);
         if (gap_idx >= 0 && i == gap_idx + 1) check("stuff_gap_bs_sending", bs_sending, 1'b0);
         rx_bit   = raw[i];
         rx_valid = 1'b1;
         rx_sop   = with_sop && (i == 0);
         rx_eop   = 1'b0;
      end
   endtask

   task automatic end_pkt(input logic v, input logic b);
      @(negedge clock);
      rx_valid = v;
      rx_bit   = b;
      rx_sop   = 1'b0;
      rx_eop   = 1'b1;
      @(negedge clock);
      rx_valid = 1'b0;
      rx_bit   = 1'b0;
      rx_eop   = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   // Monitor: every presented output is matched against the head of its queue.
   always @(negedge clock) begin : monitor
      logic [8:0] ep;
      logic [1:0] ed;
      if (reset_n) begin
         if (bs_sending) begin
            bs_count++;
            if (out_bit) ones_count++;
            check("bit_expected", exp_bits.size() != 0, 1'b1);
            if (exp_bits.size() != 0) check("out_bit", out_bit, exp_bits.pop_front());
         end
         if (pid_valid || pid_err) begin
            check("pid_event_expected", exp_pid.size() != 0, 1'b1);
            if (exp_pid.size() != 0) begin
               ep = exp_pid.pop_front();
               check("pid_valid", pid_valid, ep[8]);
               check("pid_err", pid_err, !ep[8]);
               check("pid_value", pid, ep[7:0]);
            end
         end
         if (pkt_done) begin
            check("done_expected", exp_done.size() != 0, 1'b1);
            if (exp_done.size() != 0) begin
               ed = exp_done.pop_front();
               check("len_err_at_done", len_err, ed[1]);
               check("stuff_err_at_done", stuff_err, ed[0]);
            end
         end else begin
            check("len_err_only_with_done", len_err, 1'b0);
         end
      end
   end

   initial begin : watchdog
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clock);
      check("rst_pid", pid, 8'h00);
      check("rst_out_bit", out_bit, 1'b0);
      check("rst_bs_sending", bs_sending, 1'b0);
      check("rst_pid_valid", pid_valid, 1'b0);
      check("rst_pid_err", pid_err, 1'b0);
      check("rst_stuff_err", stuff_err, 1'b0);
      check("rst_len_err", len_err, 1'b0);
      check("rst_pkt_done", pkt_done, 1'b0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // PID C3 + 16 data bits, no long runs
      bs_count = 0;
      push_pid(1'b1, 8'hC3);
      push_bits(64'h3C96, 16);
      push_done(1'b0, 1'b0);
      send(64'({16'h3C96, 8'hC3}), 24, 1'b1, -1);
      end_pkt(1'b0, 1'b0);
      check("t_basic_bs_count", bs_count, 16);
      check("t_basic_pid", pid, 8'hC3);

      // 0, eight ones with a stuffed 0 after the sixth, then seven zeros
      bs_count   = 0;
      ones_count = 0;
      push_pid(1'b1, 8'hC3);
      push_bits(64'h01FE, 16);
      push_done(1'b0, 1'b0);
      send(64'({17'h0037E, 8'hC3}), 25, 1'b1, 15);
      end_pkt(1'b0, 1'b0);
      check("t_stuff_bs_count", bs_count, 16);
      check("t_stuff_ones", ones_count, 8);

      // six ones followed by a stuffed 1
      bs_count = 0;
      push_pid(1'b1, 8'hC3);
      if (ERR_EN) begin
         push_bits(64'h7E, 7);
         push_done(1'b1, 1'b1);
      end else begin
         push_bits(64'h007E, 16);
         push_done(1'b0, 1'b0);
      end
      send(64'({17'h000FE, 8'hC3}), 25, 1'b1, -1);
      @(negedge clock);
      rx_valid = 1'b0;
      check("t_viol_stuff_err", stuff_err, ERR_EN);
      check("t_viol_bs_sending", bs_sending, !ERR_EN);
      end_pkt(1'b0, 1'b0);
      check("t_viol_bs_count", bs_count, ERR_EN ? 7 : 16);

      // bad PID 0x12, no payload
      push_pid(1'b0, 8'h12);
      push_done(1'b0, 1'b0);
      send(64'h12, 8, 1'b1, -1);
      end_pkt(1'b0, 1'b0);
      check("t_badpid_pid", pid, 8'h12);

      // 13 payload bits; bit coincident with eop is discarded
      push_pid(1'b1, 8'hC3);
      push_bits(64'h0, 13);
      push_done(1'b1, 1'b0);
      send(64'hC3, 21, 1'b1, -1);
      end_pkt(1'b1, 1'b1);

      // abort mid-DATA by a new sop, then a full packet with PID 5A
      push_pid(1'b1, 8'hC3);
      push_bits(64'h0, 5);
      push_pid(1'b1, 8'h5A);
      push_bits(64'h0, 8);
      push_done(1'b0, 1'b0);
      send(64'hC3, 13, 1'b1, -1);
      send(64'h5A, 16, 1'b1, -1);
      end_pkt(1'b0, 1'b0);
      check("t_abort_pid", pid, 8'h5A);

      // reset in the middle of a packet: no pkt_done afterwards
      push_pid(1'b1, 8'hC3);
      push_bits(64'h0, 4);
      send(64'hC3, 12, 1'b1, -1);
      @(negedge clock);
      rx_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("mid_rst_pid", pid, 8'h00);
      check("mid_rst_bs_sending", bs_sending, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      end_pkt(1'b0, 1'b0);

      check("bits_drained", exp_bits.size(), 0);
      check("pid_events_drained", exp_pid.size(), 0);
      check("done_events_drained", exp_done.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
